// File: rtl/alu_dec_pkg.sv
// Shared opcode map, FSM state type and default multi-cycle mask for the ALU op dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_dec_pkg;

    localparam logic [2:0] OP_SUM  = 3'd0;
    localparam logic [2:0] OP_CPL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_CMPC = 3'd4;
    localparam logic [2:0] OP_CMPN = 3'd5;
    localparam logic [2:0] OP_SAVE = 3'd6;
    localparam logic [2:0] OP_LOAD = 3'd7;

    // save and load are the only ops that hold the datapath for more than one cycle
    localparam logic [7:0] DEF_MULTI_MASK = 8'b1100_0000;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/alu_onehot_dec.sv
// Opcode to one-hot decode with enable; opcodes at or above N_OPS decode to zero.
// Latency: combinational.
// Backpressure: none.
module alu_onehot_dec #(
    parameter int OP_W  = 3,
    parameter int N_OPS = 8
) (
    input  logic             en,
    input  logic [OP_W-1:0]  op,
    output logic [N_OPS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_OPS; i++) begin
            if (en && (op == OP_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_dispatcher.sv
// Accepts opcodes, drives one-hot strobe/active levels for each op's latency, flags illegal opcodes.
// Latency: accept at edge k -> strobe/active in cycle k+1; done in cycle k+1 (single) or k+LAT_MULTI (multi).
// Backpressure: in_ready low while an op has cycles left; a new op may be accepted in an op's last cycle.
module alu_op_dispatcher
    import alu_dec_pkg::*;
#(
    parameter int                  OP_W       = 3,
    parameter int                  N_OPS      = 8,
    parameter logic [2**OP_W-1:0]  MULTI_MASK = (2**OP_W)'(DEF_MULTI_MASK),
    parameter int                  LAT_MULTI  = 3,
    parameter int                  CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  in_op,
    output logic             in_ready,
    output logic [N_OPS-1:0] op_strobe,
    output logic [N_OPS-1:0] op_active,
    output logic             busy,
    output logic             done,
    output logic             err_illegal,
    output logic [CNT_W-1:0] op_count
);

    // cnt holds remaining cycles after the current one, so LAT_MULTI-1 at most
    localparam int LC_W = (LAT_MULTI > 2) ? $clog2(LAT_MULTI) : 1;

    state_t           state;
    logic [LC_W-1:0]  cnt;
    logic [OP_W-1:0]  cur_op;
    logic             first;
    logic             err_q;
    logic [CNT_W-1:0] count_q;

    logic             legal;
    logic             accept;
    logic             exec;
    logic [LC_W-1:0]  lat_m1;
    logic [N_OPS-1:0] cur_onehot;

    assign legal    = ({1'b0, in_op} < (OP_W + 1)'(N_OPS));
    assign in_ready = !rst && ((state == IDLE) || ((state == EXEC) && (cnt == '0)));
    assign accept   = in_valid && in_ready;
    assign lat_m1   = MULTI_MASK[in_op] ? LC_W'(LAT_MULTI - 1) : '0;
    assign exec     = (state == EXEC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_op  <= '0;
            first   <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            err_q <= accept && !legal;
            first <= 1'b0;
            if (accept && legal) begin
                // also covers back-to-back reload from the last EXEC cycle
                state   <= EXEC;
                cur_op  <= in_op;
                cnt     <= lat_m1;
                first   <= 1'b1;
                count_q <= count_q + 1'b1;
            end else if (state == EXEC) begin
                if (cnt == '0) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    alu_onehot_dec #(
        .OP_W  (OP_W),
        .N_OPS (N_OPS)
    ) u_dec (
        .en     (exec),
        .op     (cur_op),
        .onehot (cur_onehot)
    );

    assign op_active   = cur_onehot;
    assign op_strobe   = cur_onehot & {N_OPS{first}};
    assign busy        = exec;
    assign done        = exec && (cnt == '0);
    assign err_illegal = err_q;
    assign op_count    = count_q;

    a_active_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(op_active));
    a_strobe_subset:  assert property (@(posedge clk) disable iff (rst) (op_strobe & ~op_active) == '0);

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Scoreboard bench: two dispatchers (default build, and N_OPS=6 / CNT_W=4 with op 5 multi-cycle).
// Expected ops are queued at acceptance and matched against strobes; latency, done, ready, errors and counts tracked per cycle.
module tb_alu_op_dispatcher;
    import alu_dec_pkg::*;

    typedef struct {
        logic [2:0] op;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, vld_a, rdy_a, busy_a, done_a, err_a;
    logic [2:0] op_a;
    logic [7:0] stb_a, act_a;
    logic [15:0] cnt_a;

    logic       rst_b, vld_b, rdy_b, busy_b, done_b, err_b;
    logic [2:0] op_b;
    logic [5:0] stb_b, act_b;
    logic [3:0] cnt_b;

    alu_op_dispatcher dut_a (
        .clk(clk), .rst(rst_a), .in_valid(vld_a), .in_op(op_a), .in_ready(rdy_a),
        .op_strobe(stb_a), .op_active(act_a), .busy(busy_a), .done(done_a),
        .err_illegal(err_a), .op_count(cnt_a)
    );

    alu_op_dispatcher #(
        .OP_W(3), .N_OPS(6), .MULTI_MASK(8'b0010_0000), .LAT_MULTI(3), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(vld_b), .in_op(op_b), .in_ready(rdy_b),
        .op_strobe(stb_b), .op_active(act_b), .busy(busy_b), .done(done_b),
        .err_illegal(err_b), .op_count(cnt_b)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_on   = 1'b0;
    exp_t q_a[$];
    exp_t q_b[$];

    int         act_n[2]    = '{0, 0};
    int         lat_c[2]    = '{0, 0};
    int         exp_cnt[2]  = '{0, 0};
    logic [2:0] cur[2]      = '{3'd0, 3'd0};
    bit         open[2]     = '{1'b0, 1'b0};
    bit         err_pend[2] = '{1'b0, 1'b0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int d, input logic [2:0] op);
        if (d == 0) return (op == OP_SAVE || op == OP_LOAD) ? 3 : 1;
        return (op == OP_CMPN) ? 3 : 1;
    endfunction

    task automatic mon(input int d, input logic r, input logic v, input logic rdy,
                       input logic [2:0] op, input logic [7:0] stb, input logic [7:0] act,
                       input logic bsy, input logic dn, input logic er, input logic [15:0] cnt);
        string nm;
        exp_t  e;
        bit    exp_rdy;
        int    nops;
        nm   = (d == 0) ? "a" : "b";
        nops = (d == 0) ? 8 : 6;
        if (stb != 8'h00) begin
            if (((d == 0) ? q_a.size() : q_b.size()) == 0) begin
                check_eq({nm, "_stray_strobe"}, 32'(stb), 32'h0);
            end else begin
                e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                check_eq({nm, "_strobe"}, 32'(stb), 32'(8'h01 << e.op));
                cur[d]   = e.op;
                lat_c[d] = e.lat;
                act_n[d] = 0;
                open[d]  = 1'b1;
            end
        end
        check_eq({nm, "_busy"}, 32'(bsy), 32'(open[d]));
        exp_rdy = 1'b1;
        if (open[d]) begin
            act_n[d]++;
            check_eq({nm, "_active"}, 32'(act), 32'(8'h01 << cur[d]));
            exp_rdy = (act_n[d] == lat_c[d]);
            check_eq({nm, "_done"}, 32'(dn), 32'(exp_rdy));
            if (exp_rdy) open[d] = 1'b0;
        end else begin
            check_eq({nm, "_idle_active"}, 32'(act), 32'h0);
            check_eq({nm, "_idle_done"}, 32'(dn), 32'h0);
        end
        check_eq({nm, "_in_ready"}, 32'(rdy), 32'(!r && exp_rdy));
        check_eq({nm, "_err_illegal"}, 32'(er), 32'(err_pend[d]));
        check_eq({nm, "_op_count"}, 32'(cnt), 32'(exp_cnt[d]));
        // effects of the coming edge
        err_pend[d] = 1'b0;
        if (r) begin
            if (d == 0) q_a.delete(); else q_b.delete();
            open[d]    = 1'b0;
            exp_cnt[d] = 0;
        end else if (v && rdy) begin
            if (int'(op) >= nops) begin
                err_pend[d] = 1'b1;
            end else begin
                e.op  = op;
                e.lat = lat_of(d, op);
                if (d == 0) q_a.push_back(e); else q_b.push_back(e);
                exp_cnt[d] = (exp_cnt[d] + 1) % ((d == 0) ? 65536 : 16);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0, rst_a, vld_a, rdy_a, op_a, stb_a, act_a, busy_a, done_a, err_a, cnt_a);
            mon(1, rst_b, vld_b, rdy_b, op_b, {2'b00, stb_b}, {2'b00, act_b},
                busy_b, done_b, err_b, {12'h000, cnt_b});
        end
    end

    task automatic drive(input int d, input logic v, input logic [2:0] op);
        if (d == 0) begin
            vld_a = v;
            op_a  = op;
        end else begin
            vld_b = v;
            op_b  = op;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // holds the opcode until the dispatcher takes it, bounded to 20 cycles
    task automatic issue(input int d, input logic [2:0] op);
        logic r;
        r = 1'b0;
        drive(d, 1'b1, op);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            r = (d == 0) ? rdy_a : rdy_b;
            if (r) break;
        end
        check_eq((d == 0) ? "a_ready_wait" : "b_ready_wait", 32'(r), 32'h1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        drive(0, 1'b1, OP_SUM);
        drive(1, 1'b1, OP_SUM);
        @(posedge clk);
        #1 mon_on = 1'b1;
        idle(2);
        rst_a = 1'b0; rst_b = 1'b0;
        drive(0, 1'b0, 3'd0);
        drive(1, 1'b0, 3'd0);
        idle(1);

        issue(0, OP_SHR);
        drive(0, 1'b0, 3'd0);
        idle(2);

        issue(0, OP_LOAD);
        drive(0, 1'b0, 3'd0);
        idle(4);

        issue(0, OP_SUM);
        issue(0, OP_CPL);
        issue(0, OP_SHL);
        drive(0, 1'b0, 3'd0);
        idle(2);
        check_eq("a_count_after_five", 32'(cnt_a), 32'd5);

        issue(0, OP_SAVE);
        drive(0, 1'b0, 3'd0);
        idle(1);
        rst_a = 1'b1;
        idle(1);
        rst_a = 1'b0;
        idle(2);

        issue(1, 3'd6);
        drive(1, 1'b0, 3'd0);
        idle(2);
        issue(1, OP_CMPN);
        issue(1, 3'd6);
        drive(1, 1'b0, 3'd0);
        idle(3);
        check_eq("b_count_after_illegal", 32'(cnt_b), 32'd1);

        rst_b = 1'b1;
        idle(1);
        rst_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            issue(1, 3'(i % 6));
        end
        drive(1, 1'b0, 3'd0);
        check_eq("b_count_wrap", 32'(cnt_b), 32'd0);
        idle(5);

        check_eq("a_queue_drained", 32'(q_a.size()), 32'd0);
        check_eq("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
